rca_word_sequencer: RTL and testbench

//  Multi-cycle W-bit adder built around one shared RCA_8bit instance. Processes one byte per cycle, LSB first.
//  Two requesters share the adder under round-robin arbitration. Each operation returns one result on a response channel.

---
 rtl/rca_seq_pkg.sv | 7 +
 rtl/RCA_8bit.sv | 17 +
 rtl/rca_word_sequencer.sv | 155 +++++++++++++++
 tb/tb_rca_word_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the byte-serial word adder.
package rca_seq_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;
  localparam int   BYTE_W   = 8;
  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;
endpackage

// File: rtl/RCA_8bit.sv
// 8-bit ripple-carry adder slice used by the word sequencer.
module RCA_8bit (
  output logic [7:0] sum,
  output logic       C_out,
  input  logic [7:0] A_in,
  input  logic [7:0] B_in,
  input  logic       C_in
);
  logic [8:0] c;

  assign c[0] = C_in;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign sum[i]   = A_in[i] ^ B_in[i] ^ c[i];
    assign c[i+1]   = (A_in[i] & B_in[i]) | (c[i] & (A_in[i] ^ B_in[i]));
  end
  assign C_out = c[8];
endmodule

// File: rtl/rca_word_sequencer.sv
// Two-requester W-bit adder that streams one byte per cycle through a shared RCA_8bit.
// Optional signed-overflow output enabled by macro RCA_SEQ_OVF_EN.
module rca_word_sequencer
  import rca_seq_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int W      = BYTE_W * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic         rsp_ovf
`endif
);
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             id_q, id_d, ptr_q, ptr_d;
`ifdef RCA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [BYTE_W-1:0] rca_a, rca_b, rca_s;
  logic              rca_co;
  logic              gnt0, gnt1, accept, hshake, last_byte;

  assign rca_a     = a_q[BYTE_W*idx_q +: BYTE_W];
  assign rca_b     = b_q[BYTE_W*idx_q +: BYTE_W];
  assign last_byte = (idx_q == LAST_IDX);

  RCA_8bit u_rca (
    .sum   (rca_s),
    .C_out (rca_co),
    .A_in  (rca_a),
    .B_in  (rca_b),
    .C_in  (carry_q)
  );

  // Pointer only matters on contention; a lone requester always wins.
  assign gnt0 = req0_valid && (!req1_valid || ptr_q == REQ_ID_0);
  assign gnt1 = req1_valid && (!req0_valid || ptr_q == REQ_ID_1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = ADD;
      ADD:     if (last_byte) state_d = DONE;
      DONE:    if (hshake)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && gnt0;
    req1_ready = (state_q == IDLE) && gnt1;
    rsp_valid  = (state_q == DONE);
  end

  assign accept = req0_ready || req1_ready;
  assign hshake = rsp_valid && rsp_ready;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      a_d     = req1_ready ? req1_a   : req0_a;
      b_d     = req1_ready ? req1_b   : req0_b;
      carry_d = req1_ready ? req1_cin : req0_cin;
      id_d    = req1_ready ? REQ_ID_1 : REQ_ID_0;
      idx_d   = '0;
    end
    if (state_q == ADD) begin
      sum_d[BYTE_W*idx_q +: BYTE_W] = rca_s;
      carry_d = rca_co;
      idx_d   = idx_q + 1'b1;
      if (last_byte) begin
        cout_d = rca_co;
`ifdef RCA_SEQ_OVF_EN
        // Top byte's sum MSB is the final result sign bit.
        ovf_d  = (a_q[W-1] == b_q[W-1]) && (rca_s[BYTE_W-1] != a_q[W-1]);
`endif
      end
    end
    if (hshake) ptr_d = ~id_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign rsp_id   = id_q;
`ifdef RCA_SEQ_OVF_EN
  assign rsp_ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed bench for rca_word_sequencer with a response scoreboard (NBYTES=4).
module tb_rca_word_sequencer;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0] rsp_sum;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rca_word_sequencer #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout)
`ifdef RCA_SEQ_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );
`ifndef RCA_SEQ_OVF_EN
  assign rsp_ovf = 1'b0;
`endif

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
    exp_t       e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.id   = id;
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responses are compared at the negedge before the handshake edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_rsp observed=%0h expected=none", rsp_sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_sum", rsp_sum, e.sum);
        chk("rsp_cout", rsp_cout, e.cout);
`ifdef RCA_SEQ_OVF_EN
        chk("rsp_ovf", rsp_ovf, e.ovf);
`endif
      end
    end
  end

  // Raise valid, wait for ready, record the expected result, complete the accept edge.
  task automatic send(input logic r, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n = 0;
    if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    #1;
    while (!(r ? req1_ready : req0_ready) && n < 60) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_in_time", (n < 60), 1);
    sb.push_back(model(r, a, b, cin));
    @(posedge clk); #1;
    if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("drain_in_time", (n < 60), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add with latency check
    send(0, 32'h000000FF, 32'h00000001, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, NB);
    chk("t1_sum", rsp_sum, 32'h00000100);
    drain();

    // Full carry ripple
    send(1, 32'hFFFFFFFF, 32'h00000000, 1);
    drain();

    // Round robin: pointer now favours req0
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h1; req0_b = 32'h2; req0_cin = 0;
    req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h10; req1_cin = 1;
    #1;
    chk("rr_first_r0", req0_ready, 1);
    chk("rr_first_r1", req1_ready, 0);
    send(0, 32'h1, 32'h2, 0);
    send(1, 32'hF0, 32'h10, 1);
    drain();
    @(negedge clk);
    req0_valid = 1; req0_a = 32'hA5A5A5A5; req0_b = 32'h5A5A5A5A; req0_cin = 0;
    req1_valid = 1; req1_a = 32'h7; req1_b = 32'h9; req1_cin = 0;
    #1;
    chk("rr_again_r0", req0_ready, 1);
    chk("rr_again_r1", req1_ready, 0);
    send(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
    send(1, 32'h7, 32'h9, 0);
    drain();

    // Backpressure in DONE
    rsp_ready = 1'b0;
    send(0, 32'h12345678, 32'h11111111, 1);
    req1_valid = 1; req1_a = 32'h80000000; req1_b = 32'h80000000; req1_cin = 0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_valid_rise", n, NB);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_sum, 32'h2345678A);
      chk("bp_cout", rsp_cout, 0);
      chk("bp_id", rsp_id, 0);
      chk("bp_no_r1_ready", req1_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    send(1, 32'h80000000, 32'h80000000, 0);
    drain();

    // Reset mid-ADD; first leave pointer favouring req1
    send(0, 32'h00000010, 32'h00000020, 0);
    drain();
    send(0, 32'hDEADBEEF, 32'h01010101, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    chk("abort_valid", rsp_valid, 0);
    chk("abort_sum", rsp_sum, 0);
    chk("abort_cout", rsp_cout, 0);
    chk("abort_id", rsp_id, 0);
    rst_n = 1'b1;
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h0000FFFF; req0_b = 32'h00000001; req0_cin = 0;
    req1_valid = 1; req1_a = 32'h3; req1_b = 32'h4; req1_cin = 0;
    #1;
    chk("abort_ptr_r0", req0_ready, 1);
    chk("abort_ptr_r1", req1_ready, 0);
    send(0, 32'h0000FFFF, 32'h00000001, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("abort_next_sum", rsp_sum, 32'h00010000);
    send(1, 32'h3, 32'h4, 0);
    drain();

`ifdef RCA_SEQ_OVF_EN
    send(0, 32'h7FFFFFFF, 32'h00000001, 0);
    drain();
    send(0, 32'hFFFFFFFF, 32'h00000001, 0);
    drain();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
